h14tx_island_sequencer: RTL and testbench
=========================================

# h14tx_island_sequencer

Generates the complete three-channel symbol stream for one HDMI 1.4 data island: a control-period preamble, the leading guard band, N 32-clock TERC4-coded packets and the trailing guard band. The per-channel TERC4 encoder handles one 4-bit word. This block adds the sequencing, guard bands, preamble control tokens, channel-0 sync/header packing and a read handshake to the packet source. It sits between the packet assembler (upstream, show-ahead source) and the per-channel serialisers. Downstream muxing uses `island`/`busy` to choose between this stream and the video/control path.

## Interface
- `PREAMBLE_LEN`, default 8: control-period preamble length in clocks (≥1).
- `GUARD_LEN`, default 2: guard-band length in clocks (≥1).
- `MAX_PACKETS`, default 18: maximum packets per island (≥1).
- `PACKET_LEN`, default 32: clocks per packet.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request an island; honoured only in IDLE.
- `num_packets` in $clog2(MAX_PACKETS+1): packet count, sampled with `start`.
- `hsync`, `vsync` in 1 each: live sync levels, sampled every clock.
- `pkt_hdr` in 1: header bit for channel 0 bit 2.
- `pkt_ch1`, `pkt_ch2` in 4 each: TERC4 data for channels 1 and 2.
- `pkt_valid` in 1: source has a word available.
- `pkt_rd` out 1: word consumed this clock (combinational from state).
- `sym_ch0`, `sym_ch1`, `sym_ch2` out 10 each: registered symbols.
- `island` out 1: outputs carry guard or packet symbols.
- `busy` out 1: sequence in progress.
- `underrun` out 1: sticky; a read occurred while `pkt_valid` was low.

## Operation
- **States:** IDLE → PRE → LGB → DATA → TGB → IDLE.
- **Counters:**
  - A phase counter runs to PREAMBLE_LEN/GUARD_LEN/PACKET_LEN minus 1.
  - A packet counter runs to the latched count minus 1.
- **Start handling:**
  - `start` is honoured in IDLE only when `num_packets` ≠ 0; a zero count is ignored.
  - Values above MAX_PACKETS are clamped to MAX_PACKETS.
  - `start` in any non-IDLE state is ignored.
- **Control tokens** (CTL pair c1c0): 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- **IDLE:**
  - ch0 = token({vsync,hsync}); ch1 = ch2 = token(00).
- **PRE:**
  - ch0 = token({vsync,hsync}); ch1 = token(01) (CTL0=1, CTL1=0); ch2 = token(01).
- **LGB/TGB:**
  - ch0 = TERC4({1,1,vsync,hsync}).
  - ch1 = ch2 = 0100110011.
- **DATA:**
  - `pkt_rd` = 1 every clock.
  - ch0 = TERC4({b3,pkt_hdr,vsync,hsync}), where b3 = 0 only on the first DATA clock of the island and 1 otherwise.
  - ch1 = TERC4(pkt_ch1); ch2 = TERC4(pkt_ch2).
- **TERC4 table** (data→symbol):
  - 0→1010011100, 1→1001100011, 2→1011100100, 3→1011100010
  - 4→0101110001, 5→0100011110, 6→0110001110, 7→0100111100
  - 8→1011001100, 9→0100111001, A→0110011100, B→1011000110
  - C→1010001110, D→1001110001, E→0101100011, F→1011000011
- **Underrun:**
  - `pkt_rd`=1 with `pkt_valid`=0 encodes pkt_hdr=0 and data 0.
  - The sequence continues without stalling.
  - `underrun` sets and stays set until `rst` or an accepted `start`.

## Timing
- **Reset values:** state IDLE, counters 0, sym_ch0/1/2 = 1101010100, island = 0, busy = 0, underrun = 0, pkt_rd = 0.
- **Reset mid-sequence:** IDLE and reset values on the next clock; the partial island is abandoned and no further `pkt_rd` is issued.
- **Latency:** one pipeline stage. The state at clock k determines the symbols visible after edge k+1.
  - `busy` and `island` are registered in the same stage as the symbols.
- **Sequence timing** (start accepted at edge E0):
  - The first preamble symbol is visible after E1.
  - `busy` is high for exactly PREAMBLE_LEN + 2·GUARD_LEN + PACKET_LEN·N clocks.
  - `island` is high for the last 2·GUARD_LEN + PACKET_LEN·N of those clocks.
- **Read handshake:** `pkt_rd` is high for exactly PACKET_LEN·N consecutive clocks.
  - Data is sampled at each edge where `pkt_rd`=1 and appears encoded one clock later.
- **Back-to-back islands:** TGB→IDLE is unconditional. A `start` is honoured in the first IDLE clock, giving at least one IDLE symbol between islands.
- **Sync tracking:** hsync/vsync changes inside an island take effect on the next sampled clock (no latching).

## Test plan
- **Reset:** rst=1 for 3 clocks → all syms 1101010100, busy=island=pkt_rd=underrun=0. Release with hsync=1, vsync=0 → ch0 = 0010101011.
- **Single island:** start with num_packets=1, defaults, hsync=vsync=0.
  - busy = 44 clocks, island = 36, pkt_rd = 32.
  - Preamble ch1 = ch2 = 0010101011 for 8 clocks; guards ch0 = 1010001110, ch1 = ch2 = 0100110011.
- **Channel-0 packing:** pkt_hdr=1, hsync=1, vsync=0.
  - First DATA symbol ch0 = 0100011110 (0101).
  - Second ch0 = 1001110001 (1101).
- **Data path:** pkt_ch1=0x0, pkt_ch2=0xF → ch1 = 1010011100, ch2 = 1011000011 one clock after the `pkt_rd` edge.
- **Edge cases:**
  - num_packets=0 with start → stays IDLE.
  - num_packets=25 (MAX=18) → pkt_rd high for exactly 576 clocks.
  - start during DATA → ignored.
- **Underrun and reset:**
  - Drop pkt_valid for one DATA clock → underrun=1 persists until the next accepted start; the data symbol is TERC4(0).
  - Assert rst mid-DATA → IDLE tokens on the next clock and pkt_rd=0.

Source files
------------

// File: rtl/h14tx_island_sequencer.sv
// ---------------------------------------------------------------------------
// h14tx_island_sequencer
//
// Purpose:
//   Produces the three-channel 10-bit symbol stream for one HDMI 1.4 data
//   island. One island is made of these parts, in order:
//     - a control-period preamble,
//     - the leading guard band,
//     - N TERC4-coded packets of PACKET_LEN clocks each,
//     - the trailing guard band.
//   Outside an island the block emits control-period tokens that carry the
//   live hsync/vsync levels on channel 0.
//
// Ports:
//   i_clk            pixel clock
//   i_rst            synchronous active-high reset
//   i_start          request an island (only honoured in IDLE with a nonzero count)
//   i_num_packets    packet count sampled with i_start (clamped to MAX_PACKETS)
//   i_hsync/i_vsync  live sync levels, sampled every clock
//   i_pkt_hdr        packet header bit, lands on channel 0 bit 2
//   i_pkt_ch1/ch2    TERC4 nibbles for channels 1 and 2
//   i_pkt_valid      upstream show-ahead source has a word available
//   o_pkt_rd         word consumed this clock (combinational from state)
//   o_sym_ch0/1/2    registered 10-bit symbols
//   o_island         registered: outputs carry guard or packet symbols
//   o_busy           registered: island sequence in progress
//   o_underrun       sticky: a read happened while i_pkt_valid was low
//   o_dbg_state      current FSM state, for checkers and debug
//
// Handshake: o_pkt_rd is high for every DATA clock. The word on
// pkt_hdr/pkt_ch1/pkt_ch2 is consumed at each rising edge where o_pkt_rd=1,
// and its encoded form is visible after that edge. The sequence never stalls.
// If i_pkt_valid is low on a read clock, header 0 and data 0 are encoded
// instead, and o_underrun is set.
// ---------------------------------------------------------------------------
module h14tx_island_sequencer #(
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int MAX_PACKETS  = 18,
    parameter int PACKET_LEN   = 32,
    localparam int NP_W        = $clog2(MAX_PACKETS + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [NP_W-1:0] i_num_packets,
    input  logic            i_hsync,
    input  logic            i_vsync,
    input  logic            i_pkt_hdr,
    input  logic [3:0]      i_pkt_ch1,
    input  logic [3:0]      i_pkt_ch2,
    input  logic            i_pkt_valid,
    output logic            o_pkt_rd,
    output logic [9:0]      o_sym_ch0,
    output logic [9:0]      o_sym_ch1,
    output logic [9:0]      o_sym_ch2,
    output logic            o_island,
    output logic            o_busy,
    output logic            o_underrun,
    output logic [2:0]      o_dbg_state
);

    // ------------------------------------------------------------------
    // Phase counter sizing: wide enough for the longest phase
    // ------------------------------------------------------------------
    localparam int PH_MAX0 = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int PH_MAX  = (PH_MAX0 > PACKET_LEN) ? PH_MAX0 : PACKET_LEN;
    localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] PRE_LAST = PH_W'(PREAMBLE_LEN - 1);
    localparam logic [PH_W-1:0] GRD_LAST = PH_W'(GUARD_LEN - 1);
    localparam logic [PH_W-1:0] PKT_LAST = PH_W'(PACKET_LEN - 1);
    localparam logic [NP_W-1:0] NP_MAX   = NP_W'(MAX_PACKETS);

    // ------------------------------------------------------------------
    // Fixed symbol values
    // ------------------------------------------------------------------
    localparam logic [9:0] CTL_00    = 10'b1101010100;
    localparam logic [9:0] CTL_01    = 10'b0010101011;
    localparam logic [9:0] CTL_10    = 10'b0101010100;
    localparam logic [9:0] CTL_11    = 10'b1010101011;
    localparam logic [9:0] GUARD_SYM = 10'b0100110011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_LGB  = 3'd2,
        S_DATA = 3'd3,
        S_TGB  = 3'd4
    } state_t;

    // Control-period token for the pair {c1, c0}
    function automatic logic [9:0] f_ctl(input logic [1:0] c);
        logic [9:0] sym;
        case (c)
            2'b00:   sym = CTL_00;
            2'b01:   sym = CTL_01;
            2'b10:   sym = CTL_10;
            default: sym = CTL_11;
        endcase
        return sym;
    endfunction

    // TERC4 encoding of one 4-bit word
    function automatic logic [9:0] f_terc4(input logic [3:0] d);
        logic [9:0] sym;
        case (d)
            4'h0:    sym = 10'b1010011100;
            4'h1:    sym = 10'b1001100011;
            4'h2:    sym = 10'b1011100100;
            4'h3:    sym = 10'b1011100010;
            4'h4:    sym = 10'b0101110001;
            4'h5:    sym = 10'b0100011110;
            4'h6:    sym = 10'b0110001110;
            4'h7:    sym = 10'b0100111100;
            4'h8:    sym = 10'b1011001100;
            4'h9:    sym = 10'b0100111001;
            4'hA:    sym = 10'b0110011100;
            4'hB:    sym = 10'b1011000110;
            4'hC:    sym = 10'b1010001110;
            4'hD:    sym = 10'b1001110001;
            4'hE:    sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [PH_W-1:0] r_phase;
    logic [PH_W-1:0] w_phase_nxt;
    logic [NP_W-1:0] r_pkt;
    logic [NP_W-1:0] w_pkt_nxt;
    logic [NP_W-1:0] r_count;
    logic [NP_W-1:0] w_count_nxt;
    logic            w_start_acc;

    // Output-stage registers
    logic [9:0] r_sym_ch0;
    logic [9:0] r_sym_ch1;
    logic [9:0] r_sym_ch2;
    logic       r_island;
    logic       r_busy;
    logic       r_underrun;

    // Next-symbol and datapath wires
    logic [9:0]      w_sym_ch0_nxt;
    logic [9:0]      w_sym_ch1_nxt;
    logic [9:0]      w_sym_ch2_nxt;
    logic            w_island_nxt;
    logic            w_busy_nxt;
    logic            w_underrun_nxt;
    logic            w_pkt_rd;
    logic            w_first_data;
    logic            w_hdr_eff;
    logic [3:0]      w_ch1_eff;
    logic [3:0]      w_ch2_eff;
    logic [NP_W-1:0] w_num_clamped;

    assign w_num_clamped = (i_num_packets > NP_MAX) ? NP_MAX : i_num_packets;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_pkt   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_pkt   <= w_pkt_nxt;
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 1'b1;
        w_pkt_nxt   = r_pkt;
        w_count_nxt = r_count;
        w_start_acc = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_phase_nxt = '0;
                // A zero packet count never opens an island.
                if (i_start && (i_num_packets != '0)) begin
                    w_state_nxt = S_PRE;
                    w_count_nxt = w_num_clamped;
                    w_pkt_nxt   = '0;
                    w_start_acc = 1'b1;
                end
            end

            S_PRE: begin
                if (r_phase == PRE_LAST) begin
                    w_state_nxt = S_LGB;
                    w_phase_nxt = '0;
                end
            end

            S_LGB: begin
                if (r_phase == GRD_LAST) begin
                    w_state_nxt = S_DATA;
                    w_phase_nxt = '0;
                    w_pkt_nxt   = '0;
                end
            end

            S_DATA: begin
                if (r_phase == PKT_LAST) begin
                    w_phase_nxt = '0;
                    if (r_pkt == (r_count - 1'b1)) begin
                        w_state_nxt = S_TGB;
                        w_pkt_nxt   = '0;
                    end else begin
                        w_pkt_nxt = r_pkt + 1'b1;
                    end
                end
            end

            S_TGB: begin
                // Unconditional return: the next clock is always one IDLE
                // clock, where a new start may be accepted.
                if (r_phase == GRD_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = '0;
                w_pkt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packet datapath
    // ------------------------------------------------------------------
    assign w_pkt_rd = (r_state == S_DATA);

    // Bit 3 of the channel-0 word is cleared only on the very first packet
    // clock of the island.
    assign w_first_data = (r_pkt == '0) && (r_phase == '0);

    // On an underrun, substitute header 0 and data 0 rather than stalling.
    assign w_hdr_eff = i_pkt_valid ? i_pkt_hdr : 1'b0;
    assign w_ch1_eff = i_pkt_valid ? i_pkt_ch1 : 4'h0;
    assign w_ch2_eff = i_pkt_valid ? i_pkt_ch2 : 4'h0;

    // ------------------------------------------------------------------
    // Symbol selection for the output stage
    // ------------------------------------------------------------------
    always_comb begin
        w_sym_ch0_nxt  = f_ctl({i_vsync, i_hsync});
        w_sym_ch1_nxt  = CTL_00;
        w_sym_ch2_nxt  = CTL_00;
        w_island_nxt   = 1'b0;
        w_busy_nxt     = (r_state != S_IDLE);
        w_underrun_nxt = r_underrun;

        case (r_state)
            S_PRE: begin
                // Preamble marks a data island: CTL0=1, CTL1=0, CTL2=1, CTL3=0.
                w_sym_ch1_nxt = CTL_01;
                w_sym_ch2_nxt = CTL_01;
            end

            S_LGB, S_TGB: begin
                w_sym_ch0_nxt = f_terc4({2'b11, i_vsync, i_hsync});
                w_sym_ch1_nxt = GUARD_SYM;
                w_sym_ch2_nxt = GUARD_SYM;
                w_island_nxt  = 1'b1;
            end

            S_DATA: begin
                w_sym_ch0_nxt = f_terc4({~w_first_data, w_hdr_eff, i_vsync, i_hsync});
                w_sym_ch1_nxt = f_terc4(w_ch1_eff);
                w_sym_ch2_nxt = f_terc4(w_ch2_eff);
                w_island_nxt  = 1'b1;
            end

            default: begin
                // IDLE: control tokens with the live sync levels on channel 0
            end
        endcase

        if (w_start_acc) begin
            w_underrun_nxt = 1'b0;
        end else if (w_pkt_rd && !i_pkt_valid) begin
            w_underrun_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: one register stage behind the state
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sym_ch0  <= CTL_00;
            r_sym_ch1  <= CTL_00;
            r_sym_ch2  <= CTL_00;
            r_island   <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_sym_ch0  <= w_sym_ch0_nxt;
            r_sym_ch1  <= w_sym_ch1_nxt;
            r_sym_ch2  <= w_sym_ch2_nxt;
            r_island   <= w_island_nxt;
            r_busy     <= w_busy_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign o_pkt_rd    = w_pkt_rd;
    assign o_sym_ch0   = r_sym_ch0;
    assign o_sym_ch1   = r_sym_ch1;
    assign o_sym_ch2   = r_sym_ch2;
    assign o_island    = r_island;
    assign o_busy      = r_busy;
    assign o_underrun  = r_underrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_h14tx_island_sequencer.sv
// ---------------------------------------------------------------------------
// tb_h14tx_island_sequencer
//
// Purpose:
//   Self-checking bench for h14tx_island_sequencer. A timeline model places
//   each clock after an accepted start into its island segment by arithmetic
//   on the parameter lengths. That segment, together with the inputs driven
//   during the clock, gives the symbols expected after the next edge. Those
//   expectations pass through exp_q and are compared against the DUT.
// ---------------------------------------------------------------------------
module tb_h14tx_island_sequencer;

    localparam int P    = 8;
    localparam int G    = 2;
    localparam int MAXP = 18;
    localparam int PL   = 32;
    localparam int NP_W = $clog2(MAXP + 1);
    localparam int W    = 33;

    localparam int SEG_IDLE = 0;
    localparam int SEG_PRE  = 1;
    localparam int SEG_LGB  = 2;
    localparam int SEG_DATA = 3;
    localparam int SEG_TGB  = 4;

    // ------------------------------------------------------------------
    // Clock / reset / DUT signals
    // ------------------------------------------------------------------
    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NP_W-1:0] num;
    logic            hsync;
    logic            vsync;
    logic            hdr;
    logic [3:0]      d1;
    logic [3:0]      d2;
    logic            valid;
    logic            pkt_rd;
    logic [9:0]      sym0;
    logic [9:0]      sym1;
    logic [9:0]      sym2;
    logic            island;
    logic            busy;
    logic            underrun;
    logic [2:0]      dbg_state;

    always #5 clk = ~clk;

    h14tx_island_sequencer #(
        .PREAMBLE_LEN(P),
        .GUARD_LEN   (G),
        .MAX_PACKETS (MAXP),
        .PACKET_LEN  (PL)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_packets(num),
        .i_hsync      (hsync),
        .i_vsync      (vsync),
        .i_pkt_hdr    (hdr),
        .i_pkt_ch1    (d1),
        .i_pkt_ch2    (d2),
        .i_pkt_valid  (valid),
        .o_pkt_rd     (pkt_rd),
        .o_sym_ch0    (sym0),
        .o_sym_ch1    (sym1),
        .o_sym_ch2    (sym2),
        .o_island     (island),
        .o_busy       (busy),
        .o_underrun   (underrun),
        .o_dbg_state  (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [W-1:0]    exp_q[$];

    bit              m_active = 1'b0;
    int              m_c      = 0;
    int              m_n      = 0;
    bit              m_under  = 1'b0;
    bit              m_known  = 1'b0;

    int              cnt_busy   = 0;
    int              cnt_island = 0;
    int              cnt_rd     = 0;
    logic [9:0]      last_ch0;
    logic [9:0]      last_ch1;
    logic [9:0]      last_ch2;

    function automatic logic [9:0] ctl(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] d);
        case (d)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    // Which part of the island a clock falls in, counting from the first
    // clock after the accepting edge.
    function automatic int seg_of(input int c, input int n);
        if (c < P)                return SEG_PRE;
        if (c < P + G)            return SEG_LGB;
        if (c < P + G + PL * n)   return SEG_DATA;
        if (c < P + 2 * G + PL * n) return SEG_TGB;
        return SEG_IDLE;
    endfunction

    function automatic int island_len(input int n);
        return P + 2 * G + PL * n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic rand_inputs();
        hsync = 1'($urandom_range(0, 1));
        vsync = 1'($urandom_range(0, 1));
        hdr   = 1'($urandom_range(0, 1));
        d1    = 4'($urandom_range(0, 15));
        d2    = 4'($urandom_range(0, 15));
        valid = 1'b1;
    endtask

    task automatic clear_counts();
        cnt_busy   = 0;
        cnt_island = 0;
        cnt_rd     = 0;
    endtask

    // One clock: predict from the inputs now on the pins, advance, compare.
    task automatic cycle();
        int           seg;
        bit           acc;
        logic [9:0]   e0;
        logic [9:0]   e1;
        logic [9:0]   e2;
        logic         eb;
        logic         ei;
        logic [W-1:0] e;

        seg = m_active ? seg_of(m_c, m_n) : SEG_IDLE;
        if (m_known) check("pkt_rd", 32'(pkt_rd), 32'(seg == SEG_DATA));
        if (pkt_rd === 1'b1) cnt_rd++;

        acc = 1'b0;
        e0  = ctl(2'b00);
        e1  = ctl(2'b00);
        e2  = ctl(2'b00);
        eb  = 1'b0;
        ei  = 1'b0;
        if (rst) begin
            m_under = 1'b0;
        end else begin
            case (seg)
                SEG_PRE: begin
                    e0 = ctl({vsync, hsync});
                    e1 = ctl(2'b01);
                    e2 = ctl(2'b01);
                end
                SEG_LGB, SEG_TGB: begin
                    e0 = terc4({2'b11, vsync, hsync});
                    e1 = 10'b0100110011;
                    e2 = 10'b0100110011;
                end
                SEG_DATA: begin
                    e0 = terc4({(m_c != P + G), (valid ? hdr : 1'b0), vsync, hsync});
                    e1 = terc4(valid ? d1 : 4'h0);
                    e2 = terc4(valid ? d2 : 4'h0);
                end
                default: begin
                    e0 = ctl({vsync, hsync});
                end
            endcase
            eb = (seg != SEG_IDLE);
            ei = (seg == SEG_LGB) || (seg == SEG_DATA) || (seg == SEG_TGB);
            if (seg == SEG_IDLE && start && num != 0) begin
                acc     = 1'b1;
                m_under = 1'b0;
            end else if (seg == SEG_DATA && !valid) begin
                m_under = 1'b1;
            end
        end
        exp_q.push_back({e0, e1, e2, eb, ei, m_under});

        if (rst) begin
            m_active = 1'b0;
        end else if (acc) begin
            m_active = 1'b1;
            m_c      = 0;
            m_n      = (int'(num) > MAXP) ? MAXP : int'(num);
        end else if (m_active) begin
            m_c++;
            if (m_c >= island_len(m_n)) m_active = 1'b0;
        end

        @(posedge clk);
        #1;
        m_known = 1'b1;
        e = exp_q.pop_front();
        check("sym_ch0",  32'(sym0),     32'(e[32:23]));
        check("sym_ch1",  32'(sym1),     32'(e[22:13]));
        check("sym_ch2",  32'(sym2),     32'(e[12:3]));
        check("busy",     32'(busy),     32'(e[2]));
        check("island",   32'(island),   32'(e[1]));
        check("underrun", 32'(underrun), 32'(e[0]));
        if (busy === 1'b1)   cnt_busy++;
        if (island === 1'b1) cnt_island++;
        last_ch0 = sym0;
        last_ch1 = sym1;
        last_ch2 = sym2;
    endtask

    // ------------------------------------------------------------------
    // Safety net
    // ------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL timeout: observed no end of stimulus, expected finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed and randomised stimulus
    // ------------------------------------------------------------------
    initial begin
        int n_r;
        rst   = 1'b1;
        start = 1'b0;
        num   = '0;
        hsync = 1'b0;
        vsync = 1'b0;
        hdr   = 1'b0;
        d1    = 4'h0;
        d2    = 4'h0;
        valid = 1'b1;
        #1;

        // Reset for three clocks
        repeat (3) cycle();
        check("rst_pkt_rd", 32'(pkt_rd), 32'd0);
        check("rst_sym_ch0", 32'(sym0), 32'(10'b1101010100));
        check("rst_dbg_known", 32'($isunknown(dbg_state)), 32'd0);

        // Release with hsync=1, vsync=0
        rst   = 1'b0;
        hsync = 1'b1;
        cycle();
        check("release_ch0", 32'(last_ch0), 32'(10'b0010101011));

        // Single island, one packet
        clear_counts();
        hsync = 1'b0;
        vsync = 1'b0;
        hdr   = 1'b1;
        d1    = 4'h0;
        d2    = 4'hF;
        num   = NP_W'(1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (P) cycle();
        check("pre_ch1", 32'(last_ch1), 32'(10'b0010101011));
        check("pre_ch2", 32'(last_ch2), 32'(10'b0010101011));
        repeat (G) cycle();
        check("lgb_ch0", 32'(last_ch0), 32'(10'b1010001110));
        check("lgb_ch1", 32'(last_ch1), 32'(10'b0100110011));
        hsync = 1'b1;
        cycle();
        check("data0_ch0", 32'(last_ch0), 32'(10'b0100011110));
        check("data0_ch1", 32'(last_ch1), 32'(10'b1010011100));
        check("data0_ch2", 32'(last_ch2), 32'(10'b1011000011));
        cycle();
        check("data1_ch0", 32'(last_ch0), 32'(10'b1001110001));
        repeat (PL - 2 + G + 3) begin
            rand_inputs();
            cycle();
        end
        check("single_busy_len",   32'(cnt_busy),   32'd44);
        check("single_island_len", 32'(cnt_island), 32'd36);
        check("single_rd_len",     32'(cnt_rd),     32'd32);

        // Zero packet count is ignored
        num   = '0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        check("zero_count_busy", 32'(busy), 32'd0);

        // Count above MAX is clamped; a start during DATA is ignored
        clear_counts();
        num   = NP_W'(25);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < P + 2 * G + PL * MAXP + 3; i++) begin
            rand_inputs();
            if (i == P + G + 40) begin
                start = 1'b1;
                num   = NP_W'(3);
            end else begin
                start = 1'b0;
            end
            cycle();
        end
        start = 1'b0;
        check("clamp_rd_len",   32'(cnt_rd),   32'd576);
        check("clamp_busy_len", 32'(cnt_busy), 32'd588);

        // Underrun: one missing word, sticky until the next accepted start
        num   = NP_W'(2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < island_len(2) + 2; i++) begin
            rand_inputs();
            valid = (i != P + G + 5);
            cycle();
            if (i == P + G + 5) check("underrun_sym", 32'(last_ch1), 32'(10'b1010011100));
        end
        valid = 1'b1;
        check("underrun_sticky", 32'(underrun), 32'd1);
        num   = NP_W'(1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("underrun_cleared", 32'(underrun), 32'd0);
        repeat (island_len(1)) begin
            rand_inputs();
            cycle();
        end

        // Random islands, including back-to-back starts and random drops
        for (int k = 0; k < 6; k++) begin
            n_r   = $urandom_range(1, 3);
            num   = NP_W'(n_r);
            start = 1'b1;
            cycle();
            start = 1'b0;
            repeat (island_len(n_r)) begin
                rand_inputs();
                valid = ($urandom_range(0, 7) != 0);
                cycle();
            end
            valid = 1'b1;
            repeat ($urandom_range(0, 2)) cycle();
        end

        // Reset in the middle of DATA
        num   = NP_W'(2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (P + G + 10) begin
            rand_inputs();
            cycle();
        end
        rst = 1'b1;
        cycle();
        check("midrst_pkt_rd", 32'(pkt_rd), 32'd0);
        check("midrst_ch0",    32'(sym0),   32'(10'b1101010100));
        rst   = 1'b0;
        hsync = 1'b0;
        vsync = 1'b1;
        cycle();
        check("post_rst_ch0", 32'(last_ch0), 32'(10'b0101010100));
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
